// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, IF/ID pipeline register,
// RUN/HALT syscall machine and saturating fetch/stall debug counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0000_000C,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PC_write,
  input  logic             IF_ID_write,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic             resume,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  output logic [31:0]      IF_ID_Instr,
  output logic [31:0]      IF_ID_PC4,
  output logic             IF_ID_Valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state, state_next;
  logic [31:0] pc, pc_next, pc4;
  logic        load_valid;
  logic        count_stall;

  assign imem_addr = pc;
  assign pc4       = pc + 32'd4;
  assign halted    = (state == HALT);

  // Next PC, next state and the fetch/stall qualifiers
  always_comb begin
    pc_next     = pc;
    state_next  = state;
    load_valid  = 1'b0;
    count_stall = 1'b0;

    if (br_taken) begin
      pc_next    = br_target;
      state_next = RUN;
    end else if (jump) begin
      pc_next = jump_target;
    end else if (state == HALT) begin
      if (resume) state_next = RUN;
    end else begin
      if (PC_write) pc_next = pc4;
      else          count_stall = 1'b1;
      if (IF_ID_write) begin
        load_valid = 1'b1;
        if (imem_data == HALT_INSTR) state_next = HALT;
      end
    end
  end

  // PC and state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else begin
      pc    <= pc_next;
      state <= state_next;
    end
  end

  // IF/ID register: squash on redirect, hold on stall, bubble in HALT, else load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IF_ID_Instr <= '0;
      IF_ID_PC4   <= '0;
      IF_ID_Valid <= 1'b0;
    end else if (br_taken || jump) begin
      IF_ID_Instr <= '0;
      IF_ID_PC4   <= '0;
      IF_ID_Valid <= 1'b0;
    end else if (!IF_ID_write) begin
      IF_ID_Instr <= IF_ID_Instr;
      IF_ID_PC4   <= IF_ID_PC4;
      IF_ID_Valid <= IF_ID_Valid;
    end else if (state == HALT) begin
      IF_ID_Instr <= '0;
      IF_ID_PC4   <= '0;
      IF_ID_Valid <= 1'b0;
    end else begin
      IF_ID_Instr <= imem_data;
      IF_ID_PC4   <= pc4;
      IF_ID_Valid <= 1'b1;
    end
  end

  // Saturating debug counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (load_valid && (fetch_count != '1))  fetch_count <= fetch_count + CNT_ONE;
      if (count_stall && (stall_count != '1)) stall_count <= stall_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural model checked every cycle,
// plus literal expectations at key points. A second instance with 3-bit
// counters exercises saturation.
module tb_fetch_stage;

  localparam logic [31:0] HALT_W = 32'h0000_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_write, IF_ID_write, br_taken, jump, resume;
  logic [31:0] br_target, jump_target;

  logic [31:0] imem_addr, imem_data, IF_ID_Instr, IF_ID_PC4;
  logic        IF_ID_Valid, halted;
  logic [31:0] fetch_count, stall_count;

  logic [31:0] s_addr, s_data, s_instr, s_pc4;
  logic        s_valid, s_halted;
  logic [2:0]  s_fc, s_sc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Program image: 0x20080001, 0x20080002, ... at word addresses; syscall at 0x10
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a == 32'h10) return HALT_W;
    w = 32'h2008_0000 + (a >> 2) + 32'd1;
    return w;
  endfunction

  assign imem_data = imem_word(imem_addr);
  assign s_data    = imem_word(s_addr);

  fetch_stage dut (
    .clk(clk), .rst(rst), .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .br_taken(br_taken), .br_target(br_target), .jump(jump), .jump_target(jump_target),
    .resume(resume), .imem_addr(imem_addr), .imem_data(imem_data),
    .IF_ID_Instr(IF_ID_Instr), .IF_ID_PC4(IF_ID_PC4), .IF_ID_Valid(IF_ID_Valid),
    .halted(halted), .fetch_count(fetch_count), .stall_count(stall_count)
  );

  fetch_stage #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .br_taken(br_taken), .br_target(br_target), .jump(jump), .jump_target(jump_target),
    .resume(resume), .imem_addr(s_addr), .imem_data(s_data),
    .IF_ID_Instr(s_instr), .IF_ID_PC4(s_pc4), .IF_ID_Valid(s_valid),
    .halted(s_halted), .fetch_count(s_fc), .stall_count(s_sc)
  );

  // Behavioural model: architectural PC, IF/ID contents, halt flag, raw event counts
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halt;
  longint      m_fc, m_sc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halt = 0; m_fc = 0; m_sc = 0;
    end else if (br_taken || jump) begin
      m_pc = br_taken ? br_target : jump_target;
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      if (br_taken) m_halt = 0;
    end else if (m_halt) begin
      if (IF_ID_write) begin m_instr = 0; m_pc4 = 0; m_valid = 0; end
      if (resume) m_halt = 0;
    end else begin
      logic [31:0] word;
      word = imem_word(m_pc);
      if (IF_ID_write) begin
        m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1; m_fc++;
        if (word == HALT_W) m_halt = 1;
      end
      if (PC_write) m_pc = m_pc + 32'd4;
      else          m_sc++;
    end
  end

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (64'sd1 <<< w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("imem_addr",   imem_addr,   m_pc);
    chk("IF_ID_Instr", IF_ID_Instr, m_instr);
    chk("IF_ID_PC4",   IF_ID_PC4,   m_pc4);
    chk("IF_ID_Valid", {31'b0, IF_ID_Valid}, {31'b0, m_valid});
    chk("halted",      {31'b0, halted},      {31'b0, m_halt});
    chk("fetch_count", fetch_count, 32'(sat(m_fc, 32)));
    chk("stall_count", stall_count, 32'(sat(m_sc, 32)));
    chk("s_addr",      s_addr,      m_pc);
    chk("s_fetch_count", {29'b0, s_fc}, 32'(sat(m_fc, 3)));
    chk("s_stall_count", {29'b0, s_sc}, 32'(sat(m_sc, 3)));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    PC_write = 1; IF_ID_write = 1; br_taken = 0; jump = 0; resume = 0;
  endtask

  initial begin
    rst = 1; idle(); br_target = 0; jump_target = 0;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    chk("lit_reset_pc", imem_addr, 32'h0);
    chk("lit_reset_fc", fetch_count, 32'h0);

    // Sequential fetch, then a one-cycle load-use stall at PC=8
    step(); step();
    chk("lit_seq_pc8", imem_addr, 32'h8);
    chk("lit_seq_instr", IF_ID_Instr, 32'h2008_0002);
    PC_write = 0; IF_ID_write = 0;
    step();
    chk("lit_stall_pc", imem_addr, 32'h8);
    chk("lit_stall_cnt", stall_count, 32'd1);
    idle();
    step();
    chk("lit_seq_pcC", imem_addr, 32'hC);
    chk("lit_seq_pc4", IF_ID_PC4, 32'hC);
    chk("lit_seq_fc3", fetch_count, 32'd3);

    // Syscall at 0x10 halts; resume restarts fetch at 0x14
    step(); step();
    chk("lit_halt_instr", IF_ID_Instr, HALT_W);
    chk("lit_halt_pc", imem_addr, 32'h14);
    chk("lit_halted", {31'b0, halted}, 32'd1);
    step(); step();
    chk("lit_halt_frozen", imem_addr, 32'h14);
    chk("lit_halt_bubble", {31'b0, IF_ID_Valid}, 32'd0);
    resume = 1;
    step();
    resume = 0;
    chk("lit_resumed", {31'b0, halted}, 32'd0);
    step();
    chk("lit_refetch", IF_ID_PC4, 32'h18);

    // Resume in RUN is ignored
    resume = 1; step(); resume = 0; step();

    // Branch with PC_write=0 overrides the stall and squashes IF/ID
    PC_write = 0; br_taken = 1; br_target = 32'h40;
    step();
    idle();
    chk("lit_br_pc", imem_addr, 32'h40);
    chk("lit_br_instr", IF_ID_Instr, 32'h0);
    step();

    // Branch + jump together while the syscall is being fetched: branch wins, no halt
    jump = 1; jump_target = 32'h10; step();
    br_taken = 1; br_target = 32'h80; jump = 1; jump_target = 32'h100; step();
    idle();
    chk("lit_brjmp_pc", imem_addr, 32'h80);
    chk("lit_no_halt", {31'b0, halted}, 32'd0);
    step();

    // Halt again, leave HALT via branch
    jump = 1; jump_target = 32'h10; step();
    jump = 0; step(); step();
    br_taken = 1; br_target = 32'h20; step();
    idle();
    chk("lit_br_unhalt", {31'b0, halted}, 32'd0);
    step(); step();

    // PC wrap at top of address space
    jump = 1; jump_target = 32'hFFFF_FFFC; step();
    jump = 0; step();
    chk("lit_wrap_pc", imem_addr, 32'h0);
    chk("lit_wrap_pc4", IF_ID_PC4, 32'h0);
    repeat (4) step();
    chk("lit_sat_small", {29'b0, s_fc}, 32'd7);

    // Asynchronous reset mid-cycle
    rst = 1;
    #1;
    chk("lit_async_pc", imem_addr, 32'h0);
    chk("lit_async_valid", {31'b0, IF_ID_Valid}, 32'd0);
    chk("lit_async_fc", fetch_count, 32'd0);
    step();
    rst = 0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
